fft_cadd_sub_pipe: RTL

//  Parametrised, flow-controlled complex add/subtract unit for the FFT butterfly datapath.
//  Per-transaction op select: add, subtract, reverse subtract, or a - j*b (radix-4 twiddle).
//  Per-transaction right-shift scaling with round-half-up, then signed saturation.

---
 rtl/fft_pkg.sv | 23 ++
 rtl/fft_round_sat.sv | 43 ++++
 rtl/fft_cadd_sub_pipe.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared types and helpers for the FFT complex add/subtract datapath
package fft_pkg;

    typedef enum logic [1:0] {
        ADD   = 2'd0,
        SUB   = 2'd1,
        RSUB  = 2'd2,
        SUB_J = 2'd3
    } fft_addsub_mode_e;

    localparam int SEXT_MAX = 64;

    // Replicates bit w-1 of v over every higher bit; callers keep the low DW+2 bits.
    function automatic logic [SEXT_MAX-1:0] sext(input logic [SEXT_MAX-1:0] v, input int w);
        logic [SEXT_MAX-1:0] r;
        r = v;
        for (int k = 0; k < SEXT_MAX; k++) begin
            if (k >= w) r[k] = v[w-1];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_round_sat.sv
// rtl/fft_round_sat.sv - one lane of round-half-up, arithmetic right shift and signed saturation
module fft_round_sat
    import fft_pkg::*;
#(
    parameter int DW    = 16,
    parameter int SW    = 5,
    parameter bit ROUND = 1'b1
) (
    input  logic signed [DW:0]   din,
    input  logic [SW-1:0]        sh,
    output logic signed [DW-1:0] dout,
    output logic                 sat
);
    localparam int EW = DW + 2;
    localparam logic signed [EW-1:0] MAX_V = {3'b000, {(DW-1){1'b1}}};
    localparam logic signed [EW-1:0] MIN_V = {3'b111, {(DW-1){1'b0}}};

    logic [SEXT_MAX-1:0]  wide;
    logic signed [EW-1:0] ext;
    logic signed [EW-1:0] rnd;
    logic signed [EW-1:0] v;
    logic signed [EW-1:0] shr;

    always_comb begin
        wide = sext(SEXT_MAX'(din), DW + 1);
        ext  = wide[EW-1:0];
        rnd  = '0;
        // A zero shift has no fractional part, so no rounding term.
        if (ROUND && (sh != '0)) rnd = EW'(1) << (sh - 1'b1);
        v    = ext + rnd;
        shr  = v >>> sh;
        sat  = 1'b1;
        if (shr > MAX_V) begin
            dout = MAX_V[DW-1:0];
        end else if (shr < MIN_V) begin
            dout = MIN_V[DW-1:0];
        end else begin
            dout = shr[DW-1:0];
            sat  = 1'b0;
        end
    end

endmodule

// File: rtl/fft_cadd_sub_pipe.sv
// rtl/fft_cadd_sub_pipe.sv - elastic complex add/sub/twiddle unit with scaling and saturation stats
module fft_cadd_sub_pipe
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int OUT_PIPE   = 0,
    parameter int ROUND      = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic signed [DATA_WIDTH-1:0]      opa_r,
    input  logic signed [DATA_WIDTH-1:0]      opa_i,
    input  logic signed [DATA_WIDTH-1:0]      opb_r,
    input  logic signed [DATA_WIDTH-1:0]      opb_i,
    input  logic [1:0]                        mode,
    input  logic [$clog2(DATA_WIDTH+1)-1:0]   shift,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic signed [DATA_WIDTH-1:0]      out_r,
    output logic signed [DATA_WIDTH-1:0]      out_i,
    output logic                              sat_flag,
    input  logic                              sat_clr,
    output logic [CNT_WIDTH-1:0]              sat_count
);
    localparam int DW = DATA_WIDTH;
    localparam int SW = $clog2(DW + 1);
    localparam logic [SW-1:0] SH_MAX = SW'(DW);

    logic                 s1_v, s2_v;
    logic                 s1_load, s2_load, s2_adv;
    logic signed [DW:0]   ar, ai, br, bi;
    logic signed [DW:0]   sum_r, sum_i;
    logic signed [DW:0]   s1_r, s1_i;
    logic [SW-1:0]        sh_c, s1_sh;
    logic signed [DW-1:0] rs_r, rs_i;
    logic signed [DW-1:0] s2_r, s2_i;
    logic                 sat_r, sat_i;

    // Each stage can take a new item when empty or when its item moves on.
    assign s2_load  = ~s2_v | s2_adv;
    assign s1_load  = ~s1_v | s2_load;
    assign in_ready = s1_load;

    assign ar = {opa_r[DW-1], opa_r};
    assign ai = {opa_i[DW-1], opa_i};
    assign br = {opb_r[DW-1], opb_r};
    assign bi = {opb_i[DW-1], opb_i};

    always_comb begin
        sh_c = (shift > SH_MAX) ? SH_MAX : shift;
        case (fft_addsub_mode_e'(mode))
            ADD: begin
                sum_r = ar + br;
                sum_i = ai + bi;
            end
            SUB: begin
                sum_r = ar - br;
                sum_i = ai - bi;
            end
            RSUB: begin
                sum_r = br - ar;
                sum_i = bi - ai;
            end
            default: begin
                sum_r = ar + bi;
                sum_i = ai - br;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v  <= 1'b0;
            s1_r  <= '0;
            s1_i  <= '0;
            s1_sh <= '0;
        end else if (s1_load) begin
            s1_v <= in_valid;
            if (in_valid) begin
                s1_r  <= sum_r;
                s1_i  <= sum_i;
                s1_sh <= sh_c;
            end
        end
    end

    fft_round_sat #(.DW(DW), .SW(SW), .ROUND(ROUND != 0)) u_rs_r (
        .din (s1_r),
        .sh  (s1_sh),
        .dout(rs_r),
        .sat (sat_r)
    );

    fft_round_sat #(.DW(DW), .SW(SW), .ROUND(ROUND != 0)) u_rs_i (
        .din (s1_i),
        .sh  (s1_sh),
        .dout(rs_i),
        .sat (sat_i)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_v <= 1'b0;
            s2_r <= '0;
            s2_i <= '0;
        end else if (s2_load) begin
            s2_v <= s1_v;
            if (s1_v) begin
                s2_r <= rs_r;
                s2_i <= rs_i;
            end
        end
    end

    logic                 new_sat;
    logic [1:0]           sat_inc;
    logic [CNT_WIDTH-1:0] cnt_base;
    logic [CNT_WIDTH:0]   cnt_sum;

    // A clear in the same cycle as a fresh saturation keeps only the fresh increment.
    assign new_sat  = s2_load & s1_v;
    assign sat_inc  = new_sat ? ({1'b0, sat_r} + {1'b0, sat_i}) : 2'd0;
    assign cnt_base = sat_clr ? '0 : sat_count;
    assign cnt_sum  = {1'b0, cnt_base} + (CNT_WIDTH+1)'(sat_inc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_count <= '0;
            sat_flag  <= 1'b0;
        end else begin
            sat_count <= cnt_sum[CNT_WIDTH] ? '1 : cnt_sum[CNT_WIDTH-1:0];
            sat_flag  <= (new_sat & (sat_r | sat_i)) | (sat_flag & ~sat_clr);
        end
    end

    generate
        if (OUT_PIPE != 0) begin : g_out_pipe
            logic                 s3_v;
            logic                 s3_load;
            logic signed [DW-1:0] s3_r, s3_i;

            assign s3_load = ~s3_v | out_ready;
            assign s2_adv  = s3_load;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s3_v <= 1'b0;
                    s3_r <= '0;
                    s3_i <= '0;
                end else if (s3_load) begin
                    s3_v <= s2_v;
                    if (s2_v) begin
                        s3_r <= s2_r;
                        s3_i <= s2_i;
                    end
                end
            end

            assign out_valid = s3_v;
            assign out_r     = s3_r;
            assign out_i     = s3_i;
        end else begin : g_no_pipe
            assign s2_adv    = out_ready;
            assign out_valid = s2_v;
            assign out_r     = s2_r;
            assign out_i     = s2_i;
        end
    endgenerate

endmodule
